sync_fifo: RTL

- Single-clock, parametrised FIFO; successor to the dual-clock FIFO for blocks where producer and consumer share one clock domain.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.
- Optional first-word-fall-through read mode.
- Sits between a stream producer and consumer; feeds flow-control and error-status logic upstream.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_mem.sv | 29 ++
 rtl/sync_fifo.sv | 89 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, count width helper and status bundle for sync_fifo.
package fifo_pkg;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 9;

    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: dual-port RAM, one write and one read port.
// FIFO_FWFT_EN selects an asynchronous read; otherwise the read is registered.
module fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

`ifdef FIFO_FWFT_EN
    assign rdata = mem[raddr];
`else
    // Only the output register is reset; the array contents are left undefined.
    always_ff @(posedge clk or negedge rst)
        if (!rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
`endif
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, thresholds and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int AF_THRESH  = (2**ADDR_WIDTH) - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic                  rd_req,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_almost_full,
    output logic                  fifo_almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int CW    = count_width(ADDR_WIDTH);

    if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_thresh
        $error("sync_fifo: thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  ovf, unf, wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0] rdata;
    fifo_status_t          st;

    assign st = '{
        full:         cnt == CW'(DEPTH),
        empty:        cnt == '0,
        almost_full:  cnt >= CW'(AF_THRESH),
        almost_empty: cnt <= CW'(AE_THRESH),
        overflow:     ovf,
        underflow:    unf
    };
    assign wr_ok = wr_req && !st.full;
    assign rd_ok = rd_req && !st.empty;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(wr_ok);
            rd_ptr <= rd_ptr + ADDR_WIDTH'(rd_ok);
            cnt    <= cnt + CW'(wr_ok) - CW'(rd_ok);
            // A fresh error in the clearing cycle keeps its flag set.
            ovf    <= (wr_req && st.full) || (ovf && !clr_err);
            unf    <= (rd_req && st.empty) || (unf && !clr_err);
        end

    fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

`ifdef FIFO_FWFT_EN
    assign data_out = st.empty ? '0 : rdata;
`else
    assign data_out = rdata;
`endif
    assign fifo_full         = st.full;
    assign fifo_empty        = st.empty;
    assign fifo_almost_full  = st.almost_full;
    assign fifo_almost_empty = st.almost_empty;
    assign overflow          = st.overflow;
    assign underflow         = st.underflow;
    assign fifo_count        = cnt;
endmodule
